// File: rtl/mfcc_pkg.sv
// Shared types and defaults for the MFCC front-end frame sequencing logic.
package mfcc_pkg;

    localparam int unsigned FRAME_IDX_WIDTH_DEF = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StWaitFrame,
        StWaitDs,
        StHamming,
        StMove,
        StFinish
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle-count watchdog: counts while start is high, raises expired on the
// TIMEOUT_CYCLES-th counted cycle, and restarts from zero whenever clear is high.
module seq_watchdog
    import mfcc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    // Expiry is flagged combinationally so the sequencer can act on the same edge.
    assign expired = start && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Cycle counter; holds once expired so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (start && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: hands complete frames from the window buffer to the hamming
// stage when downstream is ready, then releases the window buffer for the next move.
// Optional watchdog on the hamming stage: define FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer
    import mfcc_pkg::*;
#(
    parameter int unsigned FRAME_IDX_WIDTH = FRAME_IDX_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_i,
    input  logic [FRAME_IDX_WIDTH-1:0] frame_limit_i,
    input  logic                       win_ready_i,
    input  logic                       win_idle_i,
    output logic                       win_move_o,
    input  logic                       ds_ready_i,
    output logic                       ham_start_o,
    input  logic                       ham_done_i,
    output logic [FRAME_IDX_WIDTH-1:0] frame_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o
);

    seq_state_e                 state_q, state_d;
    logic                       pend_q, pend_d;
    logic [FRAME_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [FRAME_IDX_WIDTH-1:0] limit_q, limit_d;
    logic                       start_q, start_d;
    logic                       move_q, move_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;

`ifdef FRAME_SEQ_WATCHDOG_EN
    logic timeout_q, timeout_d;
    logic wd_expired;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_seq_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (state_q == StHamming),
        .clear  (state_q != StHamming),
        .expired(wd_expired)
    );

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        limit_d   = limit_q;
        start_d   = 1'b0;
        move_d    = 1'b0;
        done_d    = done_q;
`ifdef FRAME_SEQ_WATCHDOG_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StWaitFrame;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    limit_d = frame_limit_i;
                end
            end
            StWaitFrame: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (pend_q) begin
                    state_d = StWaitDs;
                end
            end
            StWaitDs: begin
                if (ds_ready_i) begin
                    start_d = 1'b1;
                    state_d = StHamming;
                end
            end
            StHamming: begin
                if (ham_done_i) begin
                    idx_d = idx_q + 1'b1;
                    if ((limit_q != '0) && (idx_d == limit_q)) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                    end else if (!enable_i) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StMove;
                    end
`ifdef FRAME_SEQ_WATCHDOG_EN
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
`endif
                end
            end
            StMove: begin
                if (win_idle_i) begin
                    move_d  = 1'b1;
                    state_d = StWaitFrame;
                end
            end
            StFinish: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A ready pulse coinciding with the start clears-and-resets the flag.
        pend_d = win_ready_i | (pend_q & ~start_d);
        busy_d = (state_d != StIdle) && (state_d != StFinish);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pend_q    <= 1'b0;
            idx_q     <= '0;
            limit_q   <= '0;
            start_q   <= 1'b0;
            move_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FRAME_SEQ_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            limit_q   <= limit_d;
            start_q   <= start_d;
            move_q    <= move_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef FRAME_SEQ_WATCHDOG_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign ham_start_o = start_q;
    assign win_move_o  = move_q;
    assign frame_idx_o = idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
